// File: rtl/exe_stage_mc.sv
// -----------------------------------------------------------------------------
// exe_stage_mc
//
// Execute stage of the pipelined ARM-subset core with an iterative MUL/MLA
// unit. Single-cycle ALU operations and branch targets are registered at the
// accept edge. A multiply keeps the stage busy (in_ready low) while MUL_K
// multiplier bits are retired per cycle.
//
// Parameters
//   DATA_W  datapath width (>= 26)
//   MUL_K   multiplier bits retired per cycle (must divide DATA_W)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    abort the in-flight / incoming instruction
//   in_valid / in_ready      instruction handshake from the ID/EXE register
//   EXE_CMD                  ALU opcode
//   mul_en, mla_en           multiply / multiply-accumulate request
//   PC, signed_imm_24        PC+4 and word branch offset
//   Val_Rn, Val2, Val_Ra     operand 1, pre-shifted operand 2, accumulate
//   Sel_src1, Sel_src2       forwarding selects (01 MEM, 10 WB, else own)
//   MEM_ALU_result, WB_Value forwarded values
//   SR                       {N,Z,C,V} from the status register
//   out_valid                one-cycle pulse when the result registers load
//   ALU_result, Br_addr      registered result and branch target
//   status                   registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module exe_stage_mc #(
    parameter int DATA_W = 32,
    parameter int MUL_K  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        EXE_CMD,
    input  logic              mul_en,
    input  logic              mla_en,
    input  logic [DATA_W-1:0] PC,
    input  logic [23:0]       signed_imm_24,
    input  logic [DATA_W-1:0] Val_Rn,
    input  logic [DATA_W-1:0] Val2,
    input  logic [DATA_W-1:0] Val_Ra,
    input  logic [1:0]        Sel_src1,
    input  logic [1:0]        Sel_src2,
    input  logic [DATA_W-1:0] MEM_ALU_result,
    input  logic [DATA_W-1:0] WB_Value,
    input  logic [3:0]        SR,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] Br_addr,
    output logic [3:0]        status
);

    localparam int MSB     = DATA_W - 1;
    localparam int N_STEPS = DATA_W / MUL_K;
    localparam int CNT_W   = (N_STEPS > 2) ? $clog2(N_STEPS) : 1;
    // The accept edge already retires the first MUL_K bits, so the busy phase
    // needs N_STEPS-1 edges; the last one is reached when cnt equals N_STEPS-2.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((N_STEPS > 1) ? (N_STEPS - 2) : 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Sum of the partial products of mcand with MUL_K multiplier bits.
    function automatic logic [DATA_W-1:0] mul_step(
        input logic [DATA_W-1:0] mcand,
        input logic [MUL_K-1:0]  bits
    );
        logic [DATA_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < MUL_K; i++) begin
            if (bits[i]) begin
                sum = sum + (mcand << i);
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    // Sign-extended word offset converted to a byte offset.
    function automatic logic [DATA_W-1:0] br_offset(input logic [23:0] imm);
        logic [DATA_W-1:0] off;
        off       = '0;
        off[25:2] = imm;
        for (int i = 26; i < DATA_W; i++) begin
            off[i] = imm[23];
        end
        return off;
    endfunction

    state_t            state_r, state_next;
    logic [DATA_W-1:0] mcand_r, mplier_r, acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        sr_cv_r;
    logic [DATA_W-1:0] br_hold_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] alu_result_r, br_addr_r;
    logic [3:0]        status_r;

    logic [DATA_W-1:0] op1_s, op2_s, b_eff_s, logic_res_s, alu_res_s;
    logic [DATA_W:0]   sum_s;
    logic              cin_s, is_arith_s, c_flag_s, v_flag_s;
    logic [3:0]        alu_flags_s;
    logic [DATA_W-1:0] br_addr_s, acc0_s, first_acc_s, mul_next_acc_s;
    logic [DATA_W-1:0] retire_res_s, retire_br_s;
    logic [1:0]        retire_cv_s;
    logic              in_ready_s, is_mul_s, accept_s;
    logic              load_single_s, mul_start_s, mul_adv_s, mul_done_s;
    logic              unused_sr_s;

    assign unused_sr_s = &{1'b0, SR[3:2]};

    assign in_ready_s = (state_r == ST_IDLE);
    assign is_mul_s   = mul_en | mla_en;
    assign accept_s   = in_valid & in_ready_s & ~flush;
    assign br_addr_s  = PC + br_offset(signed_imm_24);

    // Operand forwarding muxes.
    always_comb begin
        op1_s = Val_Rn;
        op2_s = Val2;
        case (Sel_src1)
            2'b01:   op1_s = MEM_ALU_result;
            2'b10:   op1_s = WB_Value;
            default: op1_s = Val_Rn;
        endcase
        case (Sel_src2)
            2'b01:   op2_s = MEM_ALU_result;
            2'b10:   op2_s = WB_Value;
            default: op2_s = Val2;
        endcase
    end

    // Opcode decode: logical result, or adder setup for arithmetic ops.
    // Subtraction is op1 + ~op2 + carry so the adder carry is the no-borrow flag.
    always_comb begin
        b_eff_s     = op2_s;
        cin_s       = 1'b0;
        is_arith_s  = 1'b0;
        logic_res_s = '0;
        case (EXE_CMD)
            4'b0001: logic_res_s = op2_s;
            4'b1001: logic_res_s = ~op2_s;
            4'b0010: is_arith_s  = 1'b1;
            4'b0011: begin
                is_arith_s = 1'b1;
                cin_s      = SR[1];
            end
            4'b0100: begin
                is_arith_s = 1'b1;
                b_eff_s    = ~op2_s;
                cin_s      = 1'b1;
            end
            4'b0101: begin
                is_arith_s = 1'b1;
                b_eff_s    = ~op2_s;
                cin_s      = SR[1];
            end
            4'b0110: logic_res_s = op1_s & op2_s;
            4'b0111: logic_res_s = op1_s | op2_s;
            4'b1000: logic_res_s = op1_s ^ op2_s;
            default: logic_res_s = '0;
        endcase
    end

    assign sum_s = {1'b0, op1_s} + {1'b0, b_eff_s} + {{DATA_W{1'b0}}, cin_s};

    // Result select and flag generation; non-arithmetic ops pass C/V through.
    always_comb begin
        alu_res_s = logic_res_s;
        c_flag_s  = SR[1];
        v_flag_s  = SR[0];
        if (is_arith_s) begin
            alu_res_s = sum_s[MSB:0];
            c_flag_s  = sum_s[DATA_W];
            v_flag_s  = (op1_s[MSB] == b_eff_s[MSB]) && (sum_s[MSB] != op1_s[MSB]);
        end else begin
            alu_res_s = logic_res_s;
        end
        alu_flags_s = {alu_res_s[MSB], (alu_res_s == '0), c_flag_s, v_flag_s};
    end

    // Multiplier arithmetic: first step at accept, later steps from the registers.
    assign acc0_s         = mla_en ? Val_Ra : '0;
    assign first_acc_s    = acc0_s + mul_step(op1_s, op2_s[MUL_K-1:0]);
    assign mul_next_acc_s = acc_r + mul_step(mcand_r, mplier_r[MUL_K-1:0]);

    // Values written to the result registers when a multiply completes.
    assign retire_res_s = (state_r == ST_MUL) ? mul_next_acc_s : first_acc_s;
    assign retire_cv_s  = (state_r == ST_MUL) ? sr_cv_r : SR[1:0];
    assign retire_br_s  = (state_r == ST_MUL) ? br_hold_r : br_addr_s;

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_next    = state_r;
        load_single_s = 1'b0;
        mul_start_s   = 1'b0;
        mul_adv_s     = 1'b0;
        mul_done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !is_mul_s) begin
                    load_single_s = 1'b1;
                    state_next    = ST_IDLE;
                end else if (accept_s && is_mul_s) begin
                    mul_start_s = 1'b1;
                    if (N_STEPS > 1) begin
                        state_next = ST_MUL;
                    end else begin
                        mul_done_s = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    mul_done_s = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    mul_adv_s  = 1'b1;
                    state_next = ST_MUL;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Multiplier working registers: captured at accept, shifted each busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= '0;
            mplier_r  <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            sr_cv_r   <= 2'b00;
            br_hold_r <= '0;
        end else if (mul_start_s) begin
            mcand_r   <= op1_s << MUL_K;
            mplier_r  <= op2_s >> MUL_K;
            acc_r     <= first_acc_s;
            cnt_r     <= '0;
            sr_cv_r   <= SR[1:0];
            br_hold_r <= br_addr_s;
        end else if (mul_adv_s) begin
            mcand_r  <= mcand_r << MUL_K;
            mplier_r <= mplier_r >> MUL_K;
            acc_r    <= mul_next_acc_s;
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

    // EXE/MEM result registers; they hold unless an instruction completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            alu_result_r <= '0;
            br_addr_r    <= '0;
            status_r     <= 4'b0000;
        end else if (load_single_s) begin
            out_valid_r  <= 1'b1;
            alu_result_r <= alu_res_s;
            br_addr_r    <= br_addr_s;
            status_r     <= alu_flags_s;
        end else if (mul_done_s) begin
            out_valid_r  <= 1'b1;
            alu_result_r <= retire_res_s;
            br_addr_r    <= retire_br_s;
            status_r     <= {retire_res_s[MSB], (retire_res_s == '0), retire_cv_s};
        end else begin
            out_valid_r  <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign ALU_result = alu_result_r;
    assign Br_addr    = br_addr_r;
    assign status     = status_r;

endmodule
